// File: rtl/rom_stream_src.sv
// Pattern ROM with a sequencing engine that streams a window of ROM words over valid/ready.
// Latency: start to first m_valid is 1 clock; one beat per clock while m_ready is high.
// Backpressure: m_data/m_addr/m_last hold while m_valid & !m_ready; abort drops the current word.
module rom_stream_src #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 4,
  parameter int MODE   = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] start_addr,
  input  logic [ADDR_W-1:0] count,
  input  logic              loop,
  input  logic              abort,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [DATA_W-1:0] m_data,
  output logic [ADDR_W-1:0] m_addr,
  output logic              m_last,
  output logic              busy,
  output logic              done
);

  typedef enum logic {IDLE = 1'b0, STREAM = 1'b1} state_t;

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] addr_q;   // address of the word currently presented
  logic [ADDR_W-1:0] idx_q;    // beat index within the current pass
  logic [ADDR_W-1:0] base_q;   // latched start address, reused for every loop pass
  logic [ADDR_W-1:0] cnt_q;    // latched burst length minus 1
  logic              loop_q;
  logic [DATA_W-1:0] data_q;
  logic              done_q;
  logic              xfer;     // a beat is accepted at the coming edge
  logic              at_end;   // current beat is the final one of the pass

  // ROM contents: address zero-extended or truncated to the data width, then shaped by MODE.
  function automatic logic [DATA_W-1:0] rom_word(input logic [ADDR_W-1:0] a);
    logic [DATA_W-1:0] v;
    v = DATA_W'(a);
    case (MODE)
      1:       rom_word = v;
      2:       rom_word = v ^ (v >> 1);
      default: rom_word = ~v;
    endcase
  endfunction

  assign xfer   = (state == STREAM) && m_ready;
  assign at_end = (idx_q == cnt_q);

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic: abort beats everything, a non-loop final beat closes the burst.
  always_comb begin
    state_nxt = state;
    if (abort) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE:    if (start) state_nxt = STREAM;
        STREAM:  if (xfer && at_end && !loop_q) state_nxt = IDLE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  // Burst datapath: latch the request, advance the address per beat, rewind on loop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q <= '0;
      idx_q  <= '0;
      base_q <= '0;
      cnt_q  <= '0;
      loop_q <= 1'b0;
      data_q <= '0;
      done_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (abort) begin
        // Word in flight is dropped; nothing else changes.
      end else if (state == IDLE) begin
        if (start) begin
          base_q <= start_addr;
          cnt_q  <= count;
          loop_q <= loop;
          addr_q <= start_addr;
          data_q <= rom_word(start_addr);
          idx_q  <= '0;
        end
      end else if (xfer) begin
        if (!at_end) begin
          addr_q <= addr_q + 1'b1;
          data_q <= rom_word(addr_q + 1'b1);
          idx_q  <= idx_q + 1'b1;
        end else if (loop_q) begin
          addr_q <= base_q;
          data_q <= rom_word(base_q);
          idx_q  <= '0;
        end else begin
          done_q <= 1'b1;
        end
      end
    end
  end

  // Outputs are decoded from registered state only.
  always_comb begin
    m_valid = (state == STREAM);
    busy    = (state == STREAM);
    m_last  = (state == STREAM) && at_end;
    m_data  = data_q;
    m_addr  = addr_q;
    done    = done_q;
  end

endmodule
